// File: rtl/proj_base_streamer.sv
// -----------------------------------------------------------------------------
// proj_base_streamer
//
// Transmit side of the base-stream interface that feeds the MinHash pipeline.
// A host/DMA source offers a read length and a stream of packed base words.
// The block serializes each read at one base per cycle, marks the first
// base with out_start and the final base with out_last.
//
// Optional feature macro: BASE_STREAMER_STATS_EN
//   When defined, adds the saturating counters reads_done and stall_cycles.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   in_len         in   read length in bases
//   in_len_valid   in   length offer
//   in_len_ready   out  high only while IDLE
//   in_word        in   packed bases, base i at [i*BASE_LEN +: BASE_LEN]
//   in_word_valid  in   word offer
//   in_word_ready  out  word FIFO not full
//   out_data       out  base value (0 when out_valid is low)
//   out_valid      out  out_data carries a read base
//   out_start      out  pulse with the first base of a read
//   out_last       out  high with the final base of a read
//   busy           out  state is not IDLE
//   underrun       out  sticky: FIFO ran dry mid-read, cleared by rst only
//   reads_done     out  (stats build) completed reads, saturating
//   stall_cycles   out  (stats build) underrun stall cycles, saturating
// -----------------------------------------------------------------------------
module proj_base_streamer #(
  parameter int BASE_LEN   = 2,
  parameter int WORD_BASES = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN_W-1:0]               in_len,
  input  logic                           in_len_valid,
  output logic                           in_len_ready,
  input  logic [WORD_BASES*BASE_LEN-1:0] in_word,
  input  logic                           in_word_valid,
  output logic                           in_word_ready,
  output logic [BASE_LEN-1:0]            out_data,
  output logic                           out_valid,
  output logic                           out_start,
  output logic                           out_last,
  output logic                           busy,
  output logic                           underrun
`ifdef BASE_STREAMER_STATS_EN
  ,
  output logic [15:0]                    reads_done,
  output logic [15:0]                    stall_cycles
`endif
);

  localparam int WORD_W = WORD_BASES * BASE_LEN;
  localparam int OFF_W  = $clog2(WORD_BASES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Word FIFO
  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_empty;
  logic              push, pop;

  // Read bookkeeping
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  base_idx_q;
  logic [OFF_W-1:0]  off_q;

  logic [LEN_W:0]    words_needed;
  logic [LEN_W:0]    prime_target;
  logic              prime_ok;
  logic              len_accept;
  logic              emit, stall;
  logic              is_final, word_end;
  logic [WORD_W-1:0] cur_word;
  logic [BASE_LEN-1:0] cur_base;

  // ---------------------------------------------------------------------------
  // Handshakes and FIFO status
  // ---------------------------------------------------------------------------
  assign in_len_ready  = (state_q == IDLE);
  assign in_word_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign busy          = (state_q != IDLE);
  assign fifo_empty    = (count_q == '0);
  assign push          = in_word_valid && in_word_ready;
  assign len_accept    = in_len_valid && in_len_ready && (in_len != '0);

  // Words needed for the read, computed one bit wider so a maximal length
  // cannot wrap. PRIME waits for all of them, or a full FIFO if there are more.
  assign words_needed = ({1'b0, len_q} + (LEN_W+1)'(WORD_BASES - 1)) >> OFF_W;
  assign prime_target = (words_needed > (LEN_W+1)'(FIFO_DEPTH))
                      ? (LEN_W+1)'(FIFO_DEPTH) : words_needed;
  assign prime_ok     = ((LEN_W+1)'(count_q) >= prime_target);

  // ---------------------------------------------------------------------------
  // Base selection from the head word
  // ---------------------------------------------------------------------------
  assign cur_word = fifo_mem[rd_ptr_q];
  assign cur_base = cur_word[int'(off_q)*BASE_LEN +: BASE_LEN];

  assign is_final = (base_idx_q == len_q - LEN_W'(1));
  assign word_end = (off_q == OFF_W'(WORD_BASES - 1));

  // A base can only be emitted when the head word is present; otherwise the
  // read stalls without advancing the base index.
  assign emit  = (state_q == STREAM) && !fifo_empty;
  assign stall = (state_q == STREAM) &&  fifo_empty;
  // The final word is popped even if it has unused bases left in it.
  assign pop   = emit && (word_end || is_final);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning the default first keeps every path covered, so no latch
    // is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (len_accept)        state_d = PRIME;
      PRIME:   if (prime_ok)          state_d = STREAM;
      STREAM:  if (emit && is_final)  state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      base_idx_q <= '0;
      off_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      out_last   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (len_accept) begin
        len_q      <= in_len;
        base_idx_q <= '0;
        off_q      <= '0;
      end

      out_valid <= emit;
      out_data  <= emit ? cur_base : '0;
      out_start <= emit && (base_idx_q == '0);
      out_last  <= emit && is_final;

      if (emit) begin
        base_idx_q <= base_idx_q + LEN_W'(1);
        off_q      <= pop ? '0 : off_q + OFF_W'(1);
      end

      if (stall) underrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= in_word;
  end

`ifdef BASE_STREAMER_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      reads_done   <= '0;
      stall_cycles <= '0;
    end else begin
      if (emit && is_final && (reads_done != 16'hFFFF))
        reads_done <= reads_done + 16'd1;
      if (stall && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proj_base_streamer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for proj_base_streamer (default parameters).
// A monitor compares every emitted base against a scoreboard queue filled by
// a reference model when each read is issued.
// -----------------------------------------------------------------------------
module tb_proj_base_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_len;
  logic        in_len_valid;
  logic        in_len_ready;
  logic [31:0] in_word;
  logic        in_word_valid;
  logic        in_word_ready;
  logic [1:0]  out_data;
  logic        out_valid;
  logic        out_start;
  logic        out_last;
  logic        busy;
  logic        underrun;
`ifdef BASE_STREAMER_STATS_EN
  logic [15:0] reads_done;
  logic [15:0] stall_cycles;
`endif

  proj_base_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .in_len        (in_len),
    .in_len_valid  (in_len_valid),
    .in_len_ready  (in_len_ready),
    .in_word       (in_word),
    .in_word_valid (in_word_valid),
    .in_word_ready (in_word_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_start     (out_start),
    .out_last      (out_last),
    .busy          (busy),
    .underrun      (underrun)
`ifdef BASE_STREAMER_STATS_EN
    ,
    .reads_done    (reads_done),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] data;
    logic       start;
    logic       last;
  } exp_t;

  exp_t sb[$];

  // Monitor-maintained read statistics
  int         reads_seen = 0;
  int         cur_cnt    = 0;
  int         gap        = 0;
  int         last_cnt   = 0;
  int         last_gap   = 0;
  bit         in_read    = 1'b0;
  logic [1:0] first_data = '0;
  logic [1:0] last_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: base i of the read lives in word i/16 at slot i%16.
  task automatic expect_read(input int len, input logic [31:0] w [5]);
    for (int i = 0; i < len; i++) begin
      exp_t       e;
      logic [31:0] word;
      word    = w[i / 16];
      e.data  = word[(i % 16) * 2 +: 2];
      e.start = (i == 0);
      e.last  = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  // Inputs change only at falling edges, so ready seen there holds at the
  // next rising edge.
  task automatic send_len(input logic [15:0] len);
    in_len       = len;
    in_len_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (in_len_ready) begin
        @(negedge clk);
        in_len_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_len_valid = 1'b0;
    check("len_handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_word(input logic [31:0] w);
    in_word       = w;
    in_word_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (in_word_ready) begin
        @(negedge clk);
        in_word_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_word_valid = 1'b0;
    check("word_handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_read(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (reads_seen >= target) return;
      @(negedge clk);
      #1;
    end
    check("read_timeout", reads_seen, target);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_read = 1'b0;
        cur_cnt = 0;
        continue;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data",  {30'd0, out_data},  {30'd0, e.data});
          check("out_start", {31'd0, out_start}, {31'd0, e.start});
          check("out_last",  {31'd0, out_last},  {31'd0, e.last});
        end
        if (out_start) begin
          in_read    = 1'b1;
          cur_cnt    = 0;
          gap        = 0;
          first_data = out_data;
        end
        cur_cnt++;
        if (out_last) begin
          in_read   = 1'b0;
          last_data = out_data;
          last_cnt  = cur_cnt;
          last_gap  = gap;
          reads_seen++;
        end
      end else begin
        check("idle_data_zero", {30'd0, out_data}, 32'd0);
        if (in_read) gap++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  exp_first;
    logic [1:0]  exp_last;
    int          exp_cnt;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] wa [5];
  logic [31:0] fw [6];
  int          reads_exp;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},     {31'd0, out_valid},     32'd0);
    check({tag, "_out_start"},     {31'd0, out_start},     32'd0);
    check({tag, "_out_last"},      {31'd0, out_last},      32'd0);
    check({tag, "_out_data"},      {30'd0, out_data},      32'd0);
    check({tag, "_busy"},          {31'd0, busy},          32'd0);
    check({tag, "_underrun"},      {31'd0, underrun},      32'd0);
    check({tag, "_in_len_ready"},  {31'd0, in_len_ready},  32'd1);
    check({tag, "_in_word_ready"}, {31'd0, in_word_ready}, 32'd1);
`ifdef BASE_STREAMER_STATS_EN
    check({tag, "_reads_done"},    {16'd0, reads_done},    32'd0);
    check({tag, "_stall_cycles"},  {16'd0, stall_cycles},  32'd0);
`endif
  endtask

  initial begin
    // {len, w0, w1, first base, last base, base count}
    tbl[0] = '{16'd5,  32'h000003E4, 32'h0,        2'd0, 2'd3, 5};
    tbl[1] = '{16'd1,  32'hFFFFFFFF, 32'h0,        2'd3, 2'd3, 1};
    tbl[2] = '{16'd16, 32'h1B1B1B1B, 32'h0,        2'd3, 2'd0, 16};
    tbl[3] = '{16'd17, 32'h00000000, 32'h00000002, 2'd0, 2'd2, 17};

    rst           = 1'b1;
    in_len        = '0;
    in_len_valid  = 1'b0;
    in_word       = '0;
    in_word_valid = 1'b0;
    reads_exp     = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // ---- Table-driven short reads ----
    for (int v = 0; v < 4; v++) begin
      wa = '{tbl[v].w0, tbl[v].w1, 32'h0, 32'h0, 32'h0};
      push_word(tbl[v].w0);
      if (tbl[v].len > 16) push_word(tbl[v].w1);
      expect_read(int'(tbl[v].len), wa);
      send_len(tbl[v].len);
      reads_exp++;
      wait_read(reads_exp);
      check("tbl_first_base", {30'd0, first_data}, {30'd0, tbl[v].exp_first});
      check("tbl_last_base",  {30'd0, last_data},  {30'd0, tbl[v].exp_last});
      check("tbl_base_count", last_cnt, tbl[v].exp_cnt);
      @(negedge clk);
      check("tbl_busy_after_last", {31'd0, busy}, 32'd0);
    end

    // ---- Zero length is consumed and ignored ----
    send_len(16'd0);
    repeat (4) begin
      check("len0_busy",         {31'd0, busy},         32'd0);
      check("len0_in_len_ready", {31'd0, in_len_ready}, 32'd1);
      @(negedge clk);
    end

    // ---- len=40 with all three words up front: no gaps ----
    wa = '{$urandom, $urandom, $urandom, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) push_word(wa[i]);
    expect_read(40, wa);
    send_len(16'd40);
    reads_exp++;
    wait_read(reads_exp);
    check("len40_count",    last_cnt, 40);
    check("len40_gap",      last_gap, 0);
    check("len40_underrun", {31'd0, underrun}, 32'd0);

    // ---- FIFO fill: only four of six offered words are taken ----
    for (int i = 0; i < 6; i++) fw[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fill_ready", {31'd0, in_word_ready}, (i < 4) ? 32'd1 : 32'd0);
      in_word       = fw[i];
      in_word_valid = 1'b1;
    end
    @(negedge clk);
    in_word_valid = 1'b0;
    check("fill_full_ready", {31'd0, in_word_ready}, 32'd0);

    wa = '{fw[0], fw[1], fw[2], fw[3], 32'h0};
    expect_read(64, wa);
    fork
      send_len(16'd64);
      begin
        push_word(fw[4]);
        push_word(fw[5]);
      end
    join
    reads_exp++;
    wait_read(reads_exp);
    check("len64_count", last_cnt, 64);
    check("len64_gap",   last_gap, 0);

    // The two words pushed during the 64-base read form the next read.
    wa = '{fw[4], fw[5], 32'h0, 32'h0, 32'h0};
    expect_read(20, wa);
    send_len(16'd20);
    reads_exp++;
    wait_read(reads_exp);
    check("len20_count", last_cnt, 20);

    // ---- Underrun: fifth word of an 80-base read withheld ----
    wa = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) push_word(wa[i]);
    expect_read(80, wa);
    send_len(16'd80);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (in_read && cur_cnt == 64) break;
    end
    check("stall_reached_base64", cur_cnt, 64);
    @(negedge clk);
    @(negedge clk);
    in_word       = wa[4];
    in_word_valid = 1'b1;
    @(negedge clk);
    in_word_valid = 1'b0;
    reads_exp++;
    wait_read(reads_exp);
    check("stall_count",    last_cnt, 80);
    check("stall_gap",      last_gap, 3);
    check("stall_underrun", {31'd0, underrun}, 32'd1);
`ifdef BASE_STREAMER_STATS_EN
    check("stats_stall_cycles", {16'd0, stall_cycles}, 32'd3);
    check("stats_reads_done",   {16'd0, reads_done},   reads_exp);
`endif

    // ---- Reset mid-read ----
    wa = '{$urandom, $urandom, 32'h0, 32'h0, 32'h0};
    push_word(wa[0]);
    push_word(wa[1]);
    expect_read(20, wa);
    send_len(16'd20);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (in_read && cur_cnt == 10) break;
    end
    check("rst_reached_base10", cur_cnt, 10);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    reads_exp  = 0;
    reads_seen = 0;

    // A fresh word must be the source; stale FIFO contents would mismatch.
    @(negedge clk);
    wa = '{32'hFFFF_FFE4, 32'h0, 32'h0, 32'h0, 32'h0};
    push_word(wa[0]);
    expect_read(3, wa);
    send_len(16'd3);
    reads_exp++;
    wait_read(reads_exp);
    check("post_rst_count", last_cnt, 3);
    check("post_rst_first", {30'd0, first_data}, 32'd0);
`ifdef BASE_STREAMER_STATS_EN
    check("post_rst_reads_done", {16'd0, reads_done}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
